// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// div_unit_pkg : shared divide-unit constants (ALU control codes, states, width)
// Revision     : 1.0
// ============================================================================
package div_unit_pkg;

  localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;
  localparam int         DIV_CYCLES   = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] alucontrol);
    return (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit : multi-cycle radix-2 restoring divider, result = {remainder, quotient}
// Revision : 1.0
// ============================================================================
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic                annul,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  div_state_e          state_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                qneg_q;
  logic                rneg_q;
  logic [2*DATA_W-1:0] result_q;

  logic [DATA_W-1:0]   w_op1_mag;
  logic [DATA_W-1:0]   w_op2_mag;
  logic [DATA_W:0]     w_shifted;
  logic                w_ge;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;

  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_op1_mag = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign w_op2_mag = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // The remainder stays below the divisor, so a DATA_W-bit subtract is exact whenever w_ge holds.
  always_comb begin
    w_shifted = {rem_q, quo_q[DATA_W-1]};
    w_ge      = (w_shifted >= {1'b0, div_q});
    w_diff    = w_shifted[DATA_W-1:0] - div_q;
    rem_d     = w_ge ? w_diff : w_shifted[DATA_W-1:0];
    quo_d     = {quo_q[DATA_W-2:0], w_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      quo_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (annul) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (opdata2 == '0) begin
              result_q <= {opdata1, {DATA_W{1'b1}}};
              state_q  <= DIV_DONE;
            end else begin
              quo_q   <= w_op1_mag;
              div_q   <= w_op2_mag;
              rem_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              rneg_q  <= signed_div & opdata1[DATA_W-1];
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_q <= {(rneg_q ? -rem_d : rem_d), (qneg_q ? -quo_d : quo_d)};
            state_q  <= DIV_DONE;
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = (state_q == DIV_DONE) && !annul;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// tb_div_unit : directed and random checks of div_unit against an arithmetic model
// Revision    : 1.0
// ============================================================================
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; cyc = cycle in which ready was seen (0 = timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input bit keep, input bit scramble,
                         output int cyc, output logic [63:0] res);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    cyc        = 0;
    res        = 'x;
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (ready) begin
        cyc = c;
        res = result;
        break;
      end
      @(negedge clk);
      if (scramble) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  int          lat;
  int          hits;
  logic [63:0] res;
  logic [63:0] held;
  logic [31:0] ra, rb;
  bit          rs;

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat, res);
    chk("divu_lat", lat, 34);
    chk("divu_res", res, 64'h00000002_0000000E);
    #1 chk("divu_ready_pulse", {63'd0, ready}, 64'd0);

    @(negedge clk);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, lat, res);
    chk("div_neg_lat", lat, 34);
    chk("div_neg_res", res, 64'hFFFFFFFF_FFFFFFFD);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lat, res);
    chk("div_minint_res", res, 64'h00000000_80000000);

    run_div(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0, lat, res);
    chk("dz_lat", lat, 2);
    chk("dz_res", res, 64'h00001234_FFFFFFFF);

    // Annul in cycle 10 of a 1000/3 divide.
    held = result;
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    #1 chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("busy_result_held", result, held);
    @(negedge clk);
    annul = 1'b0;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      #1 if (ready) hits++;
      @(negedge clk);
    end
    chk("annul_no_ready", hits, 0);
    chk("annul_result_held", result, held);
    run_div(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, lat, res);
    chk("post_annul_lat", lat, 34);
    chk("post_annul_res", res, 64'h00000001_0000014D);

    // Back-to-back with start held high.
    run_div(32'd50, 32'd5, 1'b0, 1'b1, 1'b0, lat, res);
    chk("b2b1_lat", lat, 34);
    chk("b2b1_res", res, 64'h00000000_0000000A);
    run_div(32'd9, 32'd4, 1'b0, 1'b0, 1'b0, lat, res);
    chk("b2b2_lat", lat, 34);
    chk("b2b2_res", res, 64'h00000001_00000002);

    // Asynchronous reset in cycle 20 of a busy divide.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int k = 2; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_result", result, 64'd0);
    chk("arst_ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd1000, 32'd7, 1'b0, 1'b0, 1'b0, lat, res);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_res", res, model(32'd1000, 32'd7, 1'b0));

    // Random operands; inputs are scrambled while busy to confirm one-time sampling.
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, 1'b0, 1'b1, lat, res);
      chk("rand_lat", lat, (rb == 32'd0) ? 2 : 34);
      chk("rand_res", res, model(ra, rb, rs));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
